// File: rtl/fifo_status_arb_if.sv
// Handshake bundle between the per-channel FIFO status inputs, the arbiter and the AXI write master.
// The master modport is the arbiter side; the slave modport is the FIFO/write-master side.
interface fifo_status_arb_if #(
  parameter int CH    = 2,
  parameter int CHW   = 1,
  parameter int CW    = 10,
  parameter int LSIZE = 9
);
  logic                  enable;
  logic [CH*CW-1:0]      count;
  logic [CH-1:0]         fifo_empty;
  logic [CH-1:0]         tail_leave;
  logic [CH*LSIZE-1:0]   tail_len;
  logic                  resp;
  logic                  done;
  logic                  burst_req;
  logic                  tail_req;
  logic [CHW-1:0]        req_ch;
  logic [LSIZE-1:0]      req_len;
  logic [CH-1:0]         burst_done;
  logic [CH-1:0]         tail_done;
  logic [CH-1:0]         timeout_err;
  logic                  rst_chain;

  modport master (
    input  enable, count, fifo_empty, tail_leave, tail_len, resp, done,
    output burst_req, tail_req, req_ch, req_len, burst_done, tail_done, timeout_err, rst_chain
  );

  modport slave (
    output enable, count, fifo_empty, tail_leave, tail_len, resp, done,
    input  burst_req, tail_req, req_ch, req_len, burst_done, tail_done, timeout_err, rst_chain
  );
endinterface

// File: rtl/fifo_status_arb.sv
// Multi-channel FIFO status arbiter: one burst/tail write request at a time, tails first, round-robin per class.
// Optional feature macro FIFO_STATUS_ARB_RST_CHAIN_EN adds a chain-reset pulse and a DRAIN state after timeout.
module fifo_status_arb #(
  parameter int CH        = 2,
  parameter int CHW       = 1,
  parameter int CW        = 10,
  parameter int LSIZE     = 9,
  parameter int THRESHOLD = 200,
  parameter int BURST_LEN = 100,
  parameter int TOW       = 24,
  parameter int TIMEOUT   = 24'hFFF000
) (
  input  logic              clock,
  input  logic              rst_n,
  fifo_status_arb_if.master bus
);

  localparam int CMPW = (CW > LSIZE) ? CW : LSIZE;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    REQ,
    WAIT_DONE,
    FSH,
    TIME_ERR
`ifdef FIFO_STATUS_ARB_RST_CHAIN_EN
    ,
    DRAIN
`endif
  } state_t;

  state_t            state_q;
  logic [CH-1:0]     tail_pend_q, tail_pend_d;
  logic [CH-1:0]     burst_ok_q, burst_ok_d;
  logic [CHW-1:0]    req_ch_q;
  logic [CHW-1:0]    last_grant_q;
  logic [LSIZE-1:0]  req_len_q;
  logic              kind_tail_q;
  logic [TOW-1:0]    to_q;
  logic              burst_req_q, tail_req_q;
  logic [CH-1:0]     burst_done_q, tail_done_q, timeout_err_q;
`ifdef FIFO_STATUS_ARB_RST_CHAIN_EN
  logic              rst_chain_q;
`endif

  logic              busy;
  logic              clr_pend;
  logic              to_hit;
  logic [CH-1:0]     cand;
  logic              win_tail;
  logic              win_valid;
  logic [CHW-1:0]    win_ch;
  logic [LSIZE-1:0]  win_len;
  int                idx;

  function automatic logic [TOW-1:0] sat_inc(input logic [TOW-1:0] v);
    return (v == {TOW{1'b1}}) ? v : v + TOW'(1);
  endfunction

  assign busy     = (state_q != IDLE);
  assign clr_pend = (state_q == FSH) || (state_q == TIME_ERR);
  assign to_hit   = (to_q == TOW'(TIMEOUT - 1));

  always_comb begin
    tail_pend_d = tail_pend_q;
    burst_ok_d  = '0;
    for (int i = 0; i < CH; i++) begin
      if (bus.tail_leave[i] &&
          (CMPW'(bus.count[i*CW +: CW]) >= CMPW'(bus.tail_len[i*LSIZE +: LSIZE])))
        tail_pend_d[i] = 1'b1;
      // A completion/timeout clear beats a same-cycle re-arm; a still-resident tail re-arms next cycle.
      if (clr_pend && (req_ch_q == CHW'(i)))
        tail_pend_d[i] = 1'b0;
      burst_ok_d[i] = (bus.count[i*CW +: CW] >= CW'(THRESHOLD)) && !bus.fifo_empty[i] &&
                      !bus.tail_leave[i] && !tail_pend_q[i] &&
                      !(busy && (req_ch_q == CHW'(i)));
    end
  end

  always_comb begin
    win_tail  = |tail_pend_q;
    cand      = win_tail ? tail_pend_q : burst_ok_q;
    win_valid = 1'b0;
    win_ch    = '0;
    idx       = 0;
    for (int k = 0; k < CH; k++) begin
      idx = (int'(last_grant_q) + 1 + k) % CH;
      if (!win_valid && cand[idx]) begin
        win_valid = 1'b1;
        win_ch    = CHW'(idx);
      end
    end
    win_len = win_tail ? bus.tail_len[int'(win_ch)*LSIZE +: LSIZE] : LSIZE'(BURST_LEN);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tail_pend_q   <= '0;
      burst_ok_q    <= '0;
      req_ch_q      <= '0;
      last_grant_q  <= CHW'(CH - 1);
      req_len_q     <= '0;
      kind_tail_q   <= 1'b0;
      to_q          <= '0;
      burst_req_q   <= 1'b0;
      tail_req_q    <= 1'b0;
      burst_done_q  <= '0;
      tail_done_q   <= '0;
      timeout_err_q <= '0;
`ifdef FIFO_STATUS_ARB_RST_CHAIN_EN
      rst_chain_q   <= 1'b0;
`endif
    end else begin
      tail_pend_q   <= tail_pend_d;
      burst_ok_q    <= burst_ok_d;
      burst_done_q  <= '0;
      tail_done_q   <= '0;
      timeout_err_q <= '0;
`ifdef FIFO_STATUS_ARB_RST_CHAIN_EN
      rst_chain_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          // Channel and length are latched here so they are stable for the whole GRANT cycle.
          if (bus.enable && win_valid) begin
            state_q      <= GRANT;
            req_ch_q     <= win_ch;
            last_grant_q <= win_ch;
            kind_tail_q  <= win_tail;
            req_len_q    <= win_len;
            to_q         <= '0;
          end
        end
        GRANT: begin
          state_q     <= REQ;
          to_q        <= '0;
          burst_req_q <= !kind_tail_q;
          tail_req_q  <= kind_tail_q;
        end
        REQ: begin
          to_q <= sat_inc(to_q);
          if (to_hit) begin
            state_q                 <= TIME_ERR;
            burst_req_q             <= 1'b0;
            tail_req_q              <= 1'b0;
            timeout_err_q[req_ch_q] <= 1'b1;
`ifdef FIFO_STATUS_ARB_RST_CHAIN_EN
            rst_chain_q             <= 1'b1;
`endif
          end else if (bus.resp) begin
            state_q     <= WAIT_DONE;
            burst_req_q <= 1'b0;
            tail_req_q  <= 1'b0;
          end
        end
        WAIT_DONE: begin
          to_q <= sat_inc(to_q);
          if (to_hit) begin
            state_q                 <= TIME_ERR;
            timeout_err_q[req_ch_q] <= 1'b1;
`ifdef FIFO_STATUS_ARB_RST_CHAIN_EN
            rst_chain_q             <= 1'b1;
`endif
          end else if (bus.done) begin
            state_q <= FSH;
            if (kind_tail_q) tail_done_q[req_ch_q]  <= 1'b1;
            else             burst_done_q[req_ch_q] <= 1'b1;
          end
        end
        FSH: state_q <= IDLE;
        TIME_ERR: begin
`ifdef FIFO_STATUS_ARB_RST_CHAIN_EN
          state_q <= DRAIN;
`else
          state_q <= IDLE;
`endif
        end
`ifdef FIFO_STATUS_ARB_RST_CHAIN_EN
        DRAIN: if (bus.fifo_empty[req_ch_q]) state_q <= IDLE;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.burst_req   = burst_req_q;
  assign bus.tail_req    = tail_req_q;
  assign bus.req_ch      = req_ch_q;
  assign bus.req_len     = req_len_q;
  assign bus.burst_done  = burst_done_q;
  assign bus.tail_done   = tail_done_q;
  assign bus.timeout_err = timeout_err_q;
`ifdef FIFO_STATUS_ARB_RST_CHAIN_EN
  assign bus.rst_chain   = rst_chain_q;
`else
  assign bus.rst_chain   = 1'b0;
`endif

endmodule
